// File: rtl/inst_prefetch_buf_pkg.sv
// Shared definitions for the instruction prefetch bridge: reset PC,
// default sequential step, fetch-cycle classification and counter sizing.
package inst_prefetch_buf_pkg;

    // Byte distance between consecutive instructions (openmips word fetch).
    localparam int ADDR_STEP_DEF = 4;

    // Program counter value the CPU fetches first after reset.
    localparam int RESET_PC = 0;

    // What the CPU fetch port is doing in the current cycle.
    typedef enum logic [1:0] {
        FK_IDLE     = 2'd0,  // ce_i low: nothing requested
        FK_HIT      = 2'd1,  // head of FIFO matches addr_i, deliver it
        FK_WAIT     = 2'd2,  // addr_i is expected but not yet buffered
        FK_REDIRECT = 2'd3   // addr_i is off the prefetched stream
    } fetch_kind_e;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO holding prefetched instructions. Pointers wrap
// naturally because DEPTH is a power of two; a separate count tells
// full from empty. Clear has priority over push and pop.
module inst_fifo
    import inst_prefetch_buf_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop && !i_clear && (r_count != '0);
    assign w_push = i_push && !i_clear && ((r_count != FULL) || w_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Data storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction-fetch bridge between the openmips fetch port and a pipelined
// instruction memory with in-order, variable latency. Sequential addresses
// are requested ahead of the CPU into a FIFO; a fetch off the predicted
// stream flushes the FIFO and discards responses already in flight.
// CPU-side outputs depend only on registered state plus ce_i/addr_i.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [SUM_W-1:0]  CREDITS  = SUM_W'(DEPTH);

    logic [ADDR_W-1:0] r_hd_addr;
    logic [ADDR_W-1:0] r_nf_addr;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop;

    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;
    logic [SUM_W-1:0]  w_occupied;
    fetch_kind_e       w_kind;
    logic              w_hit;
    logic              w_redirect;
    logic              w_issue;
    logic              w_rsp;
    logic              w_push;
    logic              w_discard;

    // Classify the CPU fetch against the head of the prefetched stream.
    always_comb begin
        w_kind = FK_IDLE;
        if (ce_i) begin
            if (addr_i != r_hd_addr) begin
                w_kind = FK_REDIRECT;
            end else if (w_count != '0) begin
                w_kind = FK_HIT;
            end else begin
                w_kind = FK_WAIT;
            end
        end
    end

    assign w_hit      = (w_kind == FK_HIT);
    assign w_redirect = (w_kind == FK_REDIRECT);

    // Buffered plus in-flight entries (stale ones included) bound new requests.
    assign w_occupied = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_issue    = (w_kind == FK_HIT || w_kind == FK_WAIT) && (w_occupied < CREDITS);

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp     = mem_rvalid_i && (r_outstanding != '0);
    assign w_push    = w_rsp && !w_redirect && (r_drop == '0);
    assign w_discard = w_rsp && !w_redirect && (r_drop != '0);

    assign inst_o     = w_hit ? w_head : '0;
    assign stall_o    = ce_i && !w_hit;
    assign mem_req_o  = w_issue;
    assign mem_addr_o = r_nf_addr;

    inst_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_redirect),
        .i_push  (w_push),
        .i_data  (mem_rdata_i),
        .i_pop   (w_hit),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Head address follows pops; a redirect restarts the stream at addr_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hd_addr <= PC_RESET;
        end else if (w_redirect) begin
            r_hd_addr <= addr_i;
        end else if (w_hit) begin
            r_hd_addr <= r_hd_addr + STEP;
        end
    end

    // Next fetch address advances with every issued request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nf_addr <= PC_RESET;
        end else if (w_redirect) begin
            r_nf_addr <= addr_i;
        end else if (w_issue) begin
            r_nf_addr <= r_nf_addr + STEP;
        end
    end

    // Requests in flight: +1 per issue, -1 per accepted response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_rsp);
        end
    end

    // Responses still owed for the abandoned stream; any arriving in the
    // redirect cycle itself is discarded there and not counted here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (w_redirect) begin
            r_drop <= r_outstanding - CNT_W'(w_rsp);
        end else if (w_discard) begin
            r_drop <= r_drop - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
module tb_inst_prefetch_buf;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] inst_o;
    logic          stall_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rvalid_i;

    inst_prefetch_buf #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i),
        .inst_o(inst_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight requests carry their address and whether
    // they still belong to the live stream; the buffer holds addresses.
    typedef struct { logic [AW-1:0] addr; logic keep; } fly_t;
    typedef struct { logic [AW-1:0] addr; int due; } mreq_t;

    fly_t          m_fly[$];
    logic [AW-1:0] m_buf[$];
    logic [AW-1:0] m_hd;
    logic [AW-1:0] m_nf;
    mreq_t         memq[$];
    int            last_due;

    int            cyc;
    logic [AW-1:0] pc;
    int            lat_min, lat_max, br_pct, ce_pct;
    bit            inject_err;
    int            n_vec, n_err;
    logic          obs_stall, obs_req;
    logic [DW-1:0] obs_inst;
    logic [AW-1:0] obs_maddr;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fly.delete();
        m_buf.delete();
        memq.delete();
        m_hd     = '0;
        m_nf     = '0;
        last_due = -100;
        pc       = '0;
    endtask

    // One CPU/memory cycle: drive just after posedge, check before negedge,
    // then advance the model to match the coming edge.
    task automatic do_cycle();
        logic          rdy, e_hit, e_redir, e_stall, e_req;
        logic [DW-1:0] e_inst;
        logic [31:0]   tmp;
        fly_t          f;
        mreq_t         q;
        int            lat;

        ce_i = ($urandom_range(99) < ce_pct);
        if (ce_i && ($urandom_range(99) < br_pct)) begin
            tmp = $urandom;
            if ($urandom_range(7) == 0) pc = 32'hFFFF_FFF0 | (tmp & 32'hC);
            else                        pc = tmp & 32'h0000_0FFC;
        end
        addr_i = pc;
        rdy = (memq.size() > 0) && (memq[0].due <= cyc);
        mem_rvalid_i = rdy || inject_err;
        mem_rdata_i  = rdy ? mem_f(memq[0].addr) : $urandom;
        #3;

        e_redir = ce_i && (addr_i != m_hd);
        e_hit   = ce_i && (m_buf.size() > 0) && (addr_i == m_hd);
        e_stall = ce_i && !e_hit;
        e_inst  = e_hit ? mem_f(m_buf[0]) : '0;
        e_req   = ce_i && !e_redir && ((m_buf.size() + m_fly.size()) < DEPTH);

        check("stall_o", 32'(stall_o), 32'(e_stall));
        check("inst_o", inst_o, e_inst);
        check("mem_req_o", 32'(mem_req_o), 32'(e_req));
        check("mem_addr_o", mem_addr_o, m_nf);
        obs_stall = stall_o;
        obs_req   = mem_req_o;
        obs_inst  = inst_o;
        obs_maddr = mem_addr_o;

        if (mem_req_o) begin
            lat    = $urandom_range(lat_max, lat_min);
            q.addr = mem_addr_o;
            q.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = q.due;
            memq.push_back(q);
        end
        if (rdy) void'(memq.pop_front());

        if (mem_rvalid_i && m_fly.size() > 0) begin
            f = m_fly.pop_front();
            if (f.keep && !e_redir) m_buf.push_back(f.addr);
        end
        if (e_redir) begin
            m_buf.delete();
            foreach (m_fly[i]) m_fly[i].keep = 1'b0;
            m_hd = addr_i;
            m_nf = addr_i;
        end else begin
            if (e_hit) begin
                void'(m_buf.pop_front());
                m_hd = m_hd + STEP;
                pc   = pc + STEP;
            end
            if (e_req) begin
                f.addr = m_nf;
                f.keep = 1'b1;
                m_fly.push_back(f);
                m_nf = m_nf + STEP;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int br, input int ce);
        lat_min = lmin; lat_max = lmax; br_pct = br; ce_pct = ce;
    endtask

    initial begin
        int first, n_st;
        bit found;

        n_vec = 0; n_err = 0; cyc = 0; inject_err = 0;
        rst = 1'b0; ce_i = 1'b0; addr_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_reset();
        #2;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_inst", inst_o, 0);
        check("rst_req", 32'(mem_req_o), 0);
        check("rst_maddr", mem_addr_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Sequential stream, fixed latency 2: first hit in cycle 3, then no stalls.
        set_knobs(2, 2, 0, 100);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            do_cycle();
            if (!obs_stall && first < 0) first = k;
        end
        check("first_hit_cycle", first, 3);
        n_st = 0;
        for (int k = 0; k < 40; k++) begin
            do_cycle();
            if (obs_stall) n_st++;
        end
        check("steady_stalls", n_st, 0);

        // Latency 6 exceeds the credit window: stalls must appear.
        set_knobs(6, 6, 0, 100);
        n_st = 0;
        for (int k = 0; k < 60; k++) begin
            do_cycle();
            if (obs_stall) n_st++;
        end
        check("long_lat_stalls_seen", 32'(n_st > 0), 1);

        // Branch to 0x100 with 3 requests in flight.
        set_knobs(4, 4, 0, 100);
        pc = 32'h40;
        for (int k = 0; k < 20 && m_fly.size() != 3; k++) do_cycle();
        check("three_in_flight", m_fly.size(), 3);
        pc = 32'h100;
        do_cycle();
        check("branch_stall", 32'(obs_stall), 1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            do_cycle();
            if (obs_req) begin
                found = 1;
                check("branch_req_addr", obs_maddr, 32'h100);
            end
        end
        check("branch_req_seen", 32'(found), 1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            do_cycle();
            if (!obs_stall) begin
                found = 1;
                check("branch_first_inst", obs_inst, mem_f(32'h100));
            end
        end
        check("branch_hit_seen", 32'(found), 1);

        // Fetch disabled for 5 cycles mid-stream, then resume without stall.
        set_knobs(3, 3, 0, 100);
        repeat (10) do_cycle();
        set_knobs(3, 3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            do_cycle();
            check("ce_off_no_req", 32'(obs_req), 0);
        end
        set_knobs(3, 3, 0, 100);
        do_cycle();
        check("resume_no_stall", 32'(obs_stall), 0);

        // Stray response with nothing outstanding must change nothing.
        set_knobs(3, 3, 0, 0);
        for (int k = 0; k < 20 && (m_fly.size() != 0 || memq.size() != 0); k++) do_cycle();
        check("idle_before_stray", m_fly.size(), 0);
        inject_err = 1;
        do_cycle();
        inject_err = 0;
        set_knobs(1, 3, 0, 100);
        repeat (15) do_cycle();

        // Randomized mix of latency, branches, wrap-around and ce gaps.
        set_knobs(1, 7, 10, 85);
        repeat (800) do_cycle();

        // Reset with two requests in flight.
        set_knobs(5, 5, 0, 100);
        pc = 32'h200;
        for (int k = 0; k < 30 && m_fly.size() != 2; k++) do_cycle();
        check("two_in_flight", m_fly.size(), 2);
        ce_i = 1'b0;
        mem_rvalid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_o), 0);
        check("mid_rst_inst", inst_o, 0);
        check("mid_rst_req", 32'(mem_req_o), 0);
        check("mid_rst_maddr", mem_addr_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_knobs(2, 2, 0, 100);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            do_cycle();
            if (!obs_stall && first < 0) first = k;
        end
        check("restart_first_hit", first, 3);
        repeat (20) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
